// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the tagged memory request/response bus.
package mem_responder_pkg;

  localparam int MEM_TAG_W = 4;
  localparam int BUS_DATA_W = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  // One slot of the fixed-latency completion pipeline.
  typedef struct packed {
    logic                  valid;
    logic [MEM_TAG_W-1:0]  tag;
    logic [BUS_DATA_W-1:0] data;
  } mem_pipe_entry_t;

endpackage

// File: rtl/mem_responder_tag_pool.sv
// Free-tag bitmap with a lowest-free-first allocator; tag 0 means "none".
module mem_tag_pool
  import mem_responder_pkg::*;
#(
  parameter int NUM_TAGS = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 allocate,
  input  logic [MEM_TAG_W-1:0] release_tag,
  output logic [MEM_TAG_W-1:0] grant_tag,
  output logic                 full
);

  logic [NUM_TAGS:1] busy;
  logic [NUM_TAGS:1] busy_next;

  // Priority encoder: scan downward so the lowest free tag wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_tag = '0;
    for (int i = NUM_TAGS; i >= 1; i--) begin
      if (!busy[i]) grant_tag = MEM_TAG_W'(i);
    end
  end

  assign full = &busy;

  // Next bitmap: set the granted tag, clear the tag completing this cycle.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (allocate && grant_tag == MEM_TAG_W'(i)) busy_next[i] = 1'b1;
      if (release_tag == MEM_TAG_W'(i))           busy_next[i] = 1'b0;
    end
  end

  // Bitmap register; reset frees every tag.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: tags requests, backs a doubleword array and
// returns completions a fixed number of cycles after acceptance.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 4,
  parameter int MEM_DEPTH   = 8192,
  parameter int NUM_TAGS    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            proc2mem_command,
  input  logic [XLEN-1:0]       proc2mem_addr,
  input  logic [BUS_DATA_W-1:0] proc2mem_data,
  output logic [MEM_TAG_W-1:0]  mem2proc_response,
  output logic [BUS_DATA_W-1:0] mem2proc_data,
  output logic [MEM_TAG_W-1:0]  mem2proc_tag
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  if (IDX_W > XLEN - 3) begin : g_bad_depth
    $error("MEM_DEPTH does not fit in the doubleword address space");
  end
  if ((1 << IDX_W) != MEM_DEPTH) begin : g_bad_pow2
    $error("MEM_DEPTH must be a power of two");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 16) begin : g_bad_latency
    $error("MEM_LATENCY must be in 1..16");
  end
  if (NUM_TAGS < 1 || NUM_TAGS > 15) begin : g_bad_tags
    $error("NUM_TAGS must be in 1..15");
  end

  logic [BUS_DATA_W-1:0] mem [MEM_DEPTH];
  mem_pipe_entry_t       pipe [MEM_LATENCY];

  logic [IDX_W-1:0]     word_idx;
  logic                 is_load;
  logic                 is_store;
  logic                 in_range;
  logic                 accept;
  logic [MEM_TAG_W-1:0] grant_tag;
  logic                 pool_full;

  // Byte offset within the doubleword has no effect on this bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^proc2mem_addr[2:0];

  assign word_idx = proc2mem_addr[3 +: IDX_W];

  // Request decode and same-cycle acknowledge.
  always_comb begin
    is_load           = (proc2mem_command == BUS_LOAD);
    is_store          = (proc2mem_command == BUS_STORE);
    in_range          = ((proc2mem_addr >> (3 + IDX_W)) == '0);
    accept            = !reset && (is_load || is_store) && in_range && !pool_full;
    mem2proc_response = accept ? grant_tag : '0;
  end

  // The tag leaving the pipeline is freed at the end of its completion cycle.
  mem_tag_pool #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_pool (
    .clock       (clock),
    .reset       (reset),
    .allocate    (accept),
    .release_tag (mem2proc_tag),
    .grant_tag   (grant_tag),
    .full        (pool_full)
  );

  // Array write port for accepted stores.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset; contents survive reset and are preloaded externally.
    if (accept && is_store) mem[word_idx] <= proc2mem_data;
  end

  // Completion shift pipeline; stage 0 captures the accepted request.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      if (accept) begin
        pipe[0] <= '{valid: 1'b1,
                     tag:   grant_tag,
                     data:  is_load ? mem[word_idx] : '0};
      end else begin
        pipe[0] <= '0;
      end
      for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mem2proc_tag  = pipe[MEM_LATENCY-1].valid ? pipe[MEM_LATENCY-1].tag  : '0;
  assign mem2proc_data = pipe[MEM_LATENCY-1].valid ? pipe[MEM_LATENCY-1].data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a latency-4 and a latency-16 instance
// share the request inputs; each scenario checks the relevant instance.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam logic [63:0] PRE_DEAD  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] ST_DATA   = 64'hAAAA_5555_0000_FFFF;
  localparam logic [63:0] BAD_DATA  = 64'h0BAD_0BAD_0BAD_0BAD;
  localparam logic [63:0] PRE_OTHER = 64'h1111_2222_3333_4444;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  resp4, tag4, resp16, tag16;
  logic [63:0] data4, data16;

  int checks = 0;
  int errors = 0;

  mem_responder #(.XLEN(32), .MEM_LATENCY(4), .MEM_DEPTH(8192), .NUM_TAGS(15)) dut_l4 (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .mem2proc_response (resp4),
    .mem2proc_data     (data4),
    .mem2proc_tag      (tag4)
  );

  mem_responder #(.XLEN(32), .MEM_LATENCY(16), .MEM_DEPTH(8192), .NUM_TAGS(15)) dut_l16 (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .mem2proc_response (resp16),
    .mem2proc_data     (data16),
    .mem2proc_tag      (tag16)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  // Move to just after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply this cycle's request, then let combinational outputs settle.
  task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    cmd   = c;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic preload(input int idx, input logic [63:0] value);
    dut_l4.mem[idx]  = value;
    dut_l16.mem[idx] = value;
  endtask

  // Two reset cycles, then one idle cycle with reset low before cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    drive(BUS_NONE, 32'h0, 64'h0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(BUS_LOAD, 32'h80, 64'h0);
    preload(16, PRE_DEAD);
    preload(32, PRE_OTHER);

    // Reset state: no grant while reset is high, idle outputs after it is sampled.
    check("rst_resp4", 64'(resp4), 64'd0);
    check("rst_resp16", 64'(resp16), 64'd0);
    tick();
    check("rst_tag4", 64'(tag4), 64'd0);
    check("rst_data4", data4, 64'd0);

    // Single load: grant tag 1, complete 4 cycles later with the preloaded word.
    do_reset();
    tick(); drive(BUS_LOAD, 32'h80, 64'h0);
    check("ld_resp", 64'(resp4), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      tick(); drive(BUS_NONE, 32'h0, 64'h0);
      check($sformatf("ld_wait%0d_tag", k), 64'(tag4), 64'd0);
    end
    tick();
    check("ld_done_tag", 64'(tag4), 64'd1);
    check("ld_done_data", data4, PRE_DEAD);
    tick();
    check("ld_after_tag", 64'(tag4), 64'd0);
    check("ld_after_data", data4, 64'd0);

    // Store then load of the same word on the next cycle.
    do_reset();
    tick(); drive(BUS_STORE, 32'h100, ST_DATA);
    check("st_resp", 64'(resp4), 64'd1);
    tick(); drive(BUS_LOAD, 32'h100, 64'h0);
    check("st_ld_resp", 64'(resp4), 64'd2);
    tick(); drive(BUS_NONE, 32'h0, 64'h0);
    tick();
    check("st_c3_tag", 64'(tag4), 64'd0);
    tick();
    check("st_done_tag", 64'(tag4), 64'd1);
    check("st_done_data", data4, 64'd0);
    tick();
    check("st_ld_done_tag", 64'(tag4), 64'd2);
    check("st_ld_done_data", data4, ST_DATA);

    // Out-of-range address is rejected; low byte-offset bits are ignored.
    do_reset();
    tick(); drive(BUS_LOAD, 32'h0010_0000, 64'h0);
    check("oor_resp", 64'(resp4), 64'd0);
    tick(); drive(BUS_LOAD, 32'h85, 64'h0);
    check("unal_resp", 64'(resp4), 64'd1);
    for (int k = 2; k <= 4; k++) begin
      tick(); drive(BUS_NONE, 32'h0, 64'h0);
      check($sformatf("oor_c%0d_tag", k), 64'(tag4), 64'd0);
    end
    tick();
    check("unal_done_tag", 64'(tag4), 64'd1);
    check("unal_done_data", data4, PRE_DEAD);
    tick();
    check("unal_after_tag", 64'(tag4), 64'd0);

    // Reset in the middle of three in-flight loads.
    do_reset();
    tick(); drive(BUS_LOAD, 32'h80, 64'h0);
    check("mr_resp0", 64'(resp4), 64'd1);
    tick(); drive(BUS_LOAD, 32'h100, 64'h0);
    check("mr_resp1", 64'(resp4), 64'd2);
    tick(); drive(BUS_LOAD, 32'h80, 64'h0);
    check("mr_resp2", 64'(resp4), 64'd3);
    tick(); reset = 1'b1; drive(BUS_LOAD, 32'h80, 64'h0);
    check("mr_rst_resp", 64'(resp4), 64'd0);
    check("mr_rst_tag", 64'(tag4), 64'd0);
    check("mr_rst_data", data4, 64'd0);
    for (int k = 4; k <= 7; k++) begin
      tick(); reset = 1'b0; drive(BUS_NONE, 32'h0, 64'h0);
      check($sformatf("mr_c%0d_tag", k), 64'(tag4), 64'd0);
      check($sformatf("mr_c%0d_data", k), data4, 64'd0);
    end
    tick(); drive(BUS_LOAD, 32'h100, 64'h0);
    check("mr_post_resp", 64'(resp4), 64'd1);
    tick(); drive(BUS_NONE, 32'h0, 64'h0);
    tick();
    tick();
    tick();
    check("mr_post_tag", 64'(tag4), 64'd1);
    check("mr_post_data", data4, ST_DATA);

    // Latency 16: exhaust all tags, reject a store while full, observe re-grant.
    preload(32, ST_DATA);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tick(); drive(BUS_LOAD, 32'h80, 64'h0);
      check($sformatf("full_resp%0d", i), 64'(resp16), 64'(i + 1));
    end
    tick(); drive(BUS_STORE, 32'h100, BAD_DATA);
    check("full_st_resp", 64'(resp16), 64'd0);
    tick(); drive(BUS_LOAD, 32'h100, 64'h0);
    check("full_c16_resp", 64'(resp16), 64'd0);
    check("full_c16_tag", 64'(tag16), 64'd1);
    check("full_c16_data", data16, PRE_DEAD);
    tick(); drive(BUS_LOAD, 32'h100, 64'h0);
    check("full_c17_resp", 64'(resp16), 64'd1);
    check("full_c17_tag", 64'(tag16), 64'd2);
    for (int c = 18; c <= 32; c++) begin
      tick(); drive(BUS_NONE, 32'h0, 64'h0);
      check($sformatf("full_c%0d_tag", c), 64'(tag16), (c <= 30) ? 64'(c - 15) : 64'd0);
    end
    tick();
    check("full_c33_tag", 64'(tag16), 64'd1);
    check("full_c33_data", data16, ST_DATA);
    tick();
    check("full_c34_tag", 64'(tag16), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
